// File: rtl/seq_comparator_if.sv
// Handshake and result bundle for the serial magnitude comparator.
interface seq_comparator_if #(parameter int WIDTH = 16);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic             zero;
  logic             sign;
  logic             borrow;
  logic [WIDTH-1:0] diff;

  modport master (output start, signed_mode, op1, op2,
                  input  busy, done, zero, sign, borrow, diff);
  modport slave  (input  start, signed_mode, op1, op2,
                  output busy, done, zero, sign, borrow, diff);
endinterface

// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: computes op1-op2 DIGIT bits per cycle,
// LSB digit first, and reports equal / less-than / borrow / difference.
module seq_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_comparator_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, dacc_q, diff_q, diff_nxt;
  logic             mode_q, brw_q, zacc_q;
  logic             zero_q, sign_q, borrow_q, done_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   d;
  logic             go, last, ovf, sign_nxt, dig_zero;

  // Start is only honoured when idle; busy starts are dropped silently.
  assign go   = (state == IDLE) && bus.start;
  assign last = (state == RUN) && (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one RUN cycle per digit, back to IDLE after the last one
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)      state_nxt = RUN;
      RUN:     if (cnt_q == LAST)  state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Digit subtract; the final digit is folded straight into the result so
  // the outputs can load on the same edge that finishes the chain.
  always_comb begin
    a_dig    = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig    = b_q[cnt_q*DIGIT +: DIGIT];
    d        = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw_q};
    dig_zero = (d[DIGIT-1:0] == '0);
    diff_nxt = dacc_q;
    diff_nxt[cnt_q*DIGIT +: DIGIT] = d[DIGIT-1:0];
    // Signed overflow: operands differ in sign and result sign left op1's.
    ovf      = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
    sign_nxt = mode_q ? (diff_nxt[WIDTH-1] ^ ovf) : d[DIGIT];
  end

  // Operand latch, borrow/zero chain and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      brw_q    <= 1'b0;
      zacc_q   <= 1'b0;
      dacc_q   <= '0;
      cnt_q    <= '0;
      diff_q   <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        a_q    <= bus.op1;
        b_q    <= bus.op2;
        mode_q <= bus.signed_mode;
        brw_q  <= 1'b0;
        zacc_q <= 1'b1;
        dacc_q <= '0;
        cnt_q  <= '0;
      end else if (state == RUN) begin
        brw_q  <= d[DIGIT];
        zacc_q <= zacc_q & dig_zero;
        dacc_q <= diff_nxt;
        if (last) begin
          cnt_q    <= '0;
          diff_q   <= diff_nxt;
          zero_q   <= zacc_q & dig_zero;
          borrow_q <= d[DIGIT];
          sign_q   <= sign_nxt;
          done_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
  assign bus.zero   = zero_q;
  assign bus.sign   = sign_q;
  assign bus.borrow = borrow_q;
  assign bus.diff   = diff_q;
endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: directed handshake checks on DIGIT=4 plus a
// randomised sweep across DIGIT=4/16/1 against an arithmetic model.
module tb_seq_comparator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  st = '0;
  logic [15:0] op1 = '0, op2 = '0;
  logic        sm = 1'b0;
  int          ncmp = 0, nmis = 0;
  logic [18:0] prev_res = '0;
  int          nexp[3] = '{4, 1, 16};

  always #5 clk = ~clk;

  seq_comparator_if #(.WIDTH(16)) if4 ();
  seq_comparator_if #(.WIDTH(16)) if16 ();
  seq_comparator_if #(.WIDTH(16)) if1 ();

  seq_comparator #(.WIDTH(16), .DIGIT(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  seq_comparator #(.WIDTH(16), .DIGIT(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  seq_comparator #(.WIDTH(16), .DIGIT(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if4.start  = st[0];  assign if16.start = st[1];  assign if1.start = st[2];
  assign if4.op1 = op1;  assign if16.op1 = op1;  assign if1.op1 = op1;
  assign if4.op2 = op2;  assign if16.op2 = op2;  assign if1.op2 = op2;
  assign if4.signed_mode = sm;  assign if16.signed_mode = sm;  assign if1.signed_mode = sm;

  // {busy, done, zero, sign, borrow, diff[15:0]} per instance
  logic [2:0][20:0] obs;
  assign obs[0] = {if4.busy,  if4.done,  if4.zero,  if4.sign,  if4.borrow,  if4.diff};
  assign obs[1] = {if16.busy, if16.done, if16.zero, if16.sign, if16.borrow, if16.diff};
  assign obs[2] = {if1.busy,  if1.done,  if1.zero,  if1.sign,  if1.borrow,  if1.diff};

  // Reference: {zero, sign, borrow, diff} straight from integer arithmetic
  function automatic logic [18:0] model(input logic [15:0] a, b, input logic m);
    int ia, ib;
    logic z, s, br;
    logic [15:0] df;
    ia = int'(a);
    ib = int'(b);
    df = 16'(ia - ib);
    br = (ia < ib);
    z  = (ia == ib);
    s  = m ? ($signed(a) < $signed(b)) : br;
    return {z, s, br, df};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One compare on the DIGIT=4 instance, cycle by cycle; optionally pokes
  // start with fresh operands while busy.
  task automatic run4(input logic [15:0] a, b, input logic m, input bit poke);
    logic [18:0] e;
    e = model(a, b, m);
    op1 = a; op2 = b; sm = m; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    op1 = 16'($urandom); op2 = 16'($urandom); sm = ~m;
    check("busy_e0", 32'(obs[0][20]), 32'(1));
    for (int k = 1; k <= 4; k++) begin
      if (poke && k == 2) begin
        st[0] = 1'b1; op1 = 16'($urandom); op2 = 16'($urandom);
      end
      @(posedge clk); #1;
      if (poke && k == 2) st[0] = 1'b0;
      if (k < 4) begin
        check("busy_run", 32'(obs[0][20]), 32'(1));
        check("done_early", 32'(obs[0][19]), 32'(0));
        check("res_hold", 32'(obs[0][18:0]), 32'(prev_res));
      end else begin
        check("busy_end", 32'(obs[0][20]), 32'(0));
        check("done_pulse", 32'(obs[0][19]), 32'(1));
        check("result", 32'(obs[0][18:0]), 32'(e));
      end
    end
    prev_res = e;
  endtask

  // Same compare on all three instances; checks latency, busy length,
  // single done pulse and result.
  task automatic run_all(input logic [15:0] a, b, input logic m);
    logic [18:0] e;
    int bc[3], dc[3], lat[3];
    e = model(a, b, m);
    op1 = a; op2 = b; sm = m; st = 3'b111;
    @(posedge clk); #1;
    st = '0; op1 = 16'($urandom); op2 = 16'($urandom); sm = ~m;
    for (int j = 0; j < 3; j++) begin
      bc[j] = int'(obs[j][20]); dc[j] = 0; lat[j] = 0;
    end
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        if (obs[j][20]) bc[j]++;
        if (obs[j][19]) begin dc[j]++; lat[j] = c; end
      end
    end
    for (int j = 0; j < 3; j++) begin
      check("sw_busy_len", 32'(bc[j]), 32'(nexp[j]));
      check("sw_done_cnt", 32'(dc[j]), 32'(1));
      check("sw_latency", 32'(lat[j]), 32'(nexp[j]));
      check("sw_result", 32'(obs[j][18:0]), 32'(e));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    int dn;
    // Reset state
    #12;
    for (int j = 0; j < 3; j++) check("reset_state", 32'(obs[j]), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Equal zeros
    run4(16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Back-to-back: second start issued in the done cycle
    run4(16'h0001, 16'h0000, 1'b0, 1'b0);
    run4(16'h0000, 16'h0001, 1'b0, 1'b0);
    check("b2b_diff", 32'(obs[0][15:0]), 32'h0000ffff);

    // Signed overflow and negative operands, both modes
    @(posedge clk); #1;
    run4(16'h8000, 16'h0001, 1'b1, 1'b0);
    check("ovf_sign", 32'(obs[0][17]), 32'(1));
    check("ovf_diff", 32'(obs[0][15:0]), 32'h00007fff);
    run4(16'h8000, 16'h0001, 1'b0, 1'b0);
    check("ovf_usign", 32'(obs[0][17]), 32'(0));
    run4(16'hffff, 16'h0001, 1'b1, 1'b0);
    run4(16'hffff, 16'h0001, 1'b0, 1'b0);

    // Start and operand changes while busy are ignored
    @(posedge clk); #1;
    run4(16'h1357, 16'h2468, 1'b1, 1'b1);
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (obs[0][19]) dn++;
      check("poke_idle", 32'(obs[0][20]), 32'(0));
      check("poke_hold", 32'(obs[0][18:0]), 32'(prev_res));
    end
    check("poke_no_extra_done", 32'(dn), 32'(0));

    // Reset in the second RUN cycle aborts
    op1 = 16'h4321; op2 = 16'h1234; sm = 1'b0; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) check("abort_outputs", 32'(obs[j]), 32'(0));
    dn = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (obs[0][19]) dn++;
    end
    check("abort_no_done", 32'(dn), 32'(0));
    prev_res = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run4(16'h1234, 16'h1234, 1'b0, 1'b0);
    check("post_abort_zero", 32'(obs[0][18]), 32'(1));

    // Randomised sweep, 500 vectors per mode, biased toward boundaries
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case (i % 8)
        0: b = a;
        1: a = 16'h8000;
        2: b = 16'h7fff;
        3: b = a + 16'd1;
        default: ;
      endcase
      run_all(a, b, logic'(i % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule

// File: doc/seq_comparator.md
Name: seq_comparator

Overview:
Parametrised multi-cycle magnitude comparator. It compares OP1 against OP2 by computing OP1-OP2 serially, DIGIT bits per cycle, LSB digit first. It reports ZERO (equal) and SIGN (OP1<OP2) in a selectable signed or unsigned mode, plus the full difference and the borrow. It sits beside the datapath as a shared compare resource with a START/BUSY/DONE handshake.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle; DIGIT=WIDTH gives single-cycle operation.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
START  input  1  request; accepted only on an edge where BUSY=0
SIGNED_MODE  input  1  1 = two's-complement compare, 0 = unsigned; latched with START
OP1  input  WIDTH  minuend; latched with START
OP2  input  WIDTH  subtrahend; latched with START
BUSY  output  1  high while a compare is in progress
DONE  output  1  one-cycle pulse: results valid and updated
ZERO  output  1  1 when OP1==OP2
SIGN  output  1  1 when OP1<OP2 in the latched mode
BORROW  output  1  unsigned borrow out of OP1-OP2
DIFF  output  WIDTH  OP1-OP2 modulo 2^WIDTH

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE; BUSY, DONE, ZERO, SIGN, BORROW = 0; DIFF = 0; digit counter = 0; operand registers cleared.
- Reset asserted mid-compare aborts the operation. No DONE is produced and the results return to reset values.
- FSM states: IDLE and RUN. N = WIDTH/DIGIT.
- IDLE:
  - On an edge E0 with START=1: latch OP1, OP2, SIGNED_MODE.
  - Clear the borrow chain to 0, set the zero accumulator to 1 and the counter to 0, then go to RUN. BUSY=1 after E0.
- RUN, edges E1..EN, one digit per edge, LSB first:
  - d = a_digit - b_digit - borrow_in, computed on DIGIT+1 bits.
  - The digit result shifts into an internal difference register; borrow_in for the next digit is the borrow out.
  - zero_acc &= (d[DIGIT-1:0]==0).
- Final edge EN:
  - DIFF, ZERO, BORROW and SIGN register their values.
  - BUSY goes to 0 and DONE goes to 1 for exactly one cycle. State returns to IDLE.
- Latency: BUSY is high for exactly N cycles, and DONE is asserted N cycles after the START edge.
- Result equations:
  - ZERO = zero_acc. It is mode independent.
  - BORROW = final borrow out.
  - Unsigned: SIGN = BORROW.
  - Signed: SIGN = DIFF[WIDTH-1] XOR V, where V = (a[MSB]!=b[MSB]) && (DIFF[MSB]!=a[MSB]). SIGN stays correct on overflow.
  - ZERO=1 always implies SIGN=0.
- Result outputs (DIFF, ZERO, SIGN, BORROW) hold their values from one DONE until the next DONE. They do not change during RUN.
- START while BUSY=1 is ignored. The operand registers are not disturbed.
- Back-to-back operation: START high in the DONE cycle (BUSY=0) is accepted, so a new compare begins with no idle gap.
- OP1/OP2/SIGNED_MODE changing after the START edge have no effect on the current compare.
- The counter wraps from N-1 back to 0 on exit from RUN. Its width is clog2(N), minimum 1.

Test Plan:
1. Reset, then START with OP1=0000, OP2=0000, unsigned (WIDTH=16, DIGIT=4) -> BUSY high 4 cycles; DONE pulses 4 cycles after the START edge; ZERO=1, SIGN=0, BORROW=0, DIFF=0000.
2. OP1=0001, OP2=0000, then a back-to-back START in the DONE cycle with OP1=0000, OP2=0001 -> first: ZERO=0, SIGN=0, DIFF=0001; second DONE 4 cycles later: ZERO=0, SIGN=1, BORROW=1, DIFF=FFFF.
3. OP1=8000, OP2=0001: signed -> SIGN=1, DIFF=7FFF, BORROW=0 (overflow case); unsigned -> SIGN=0. Also OP1=FFFF, OP2=0001 signed -> SIGN=1; unsigned -> SIGN=0.
4. START pulsed again, and OP1/OP2 changed, during BUSY -> ignored; results match the originally latched operands; exactly one DONE.
5. RST_N pulled low in the 2nd RUN cycle -> outputs go to 0 immediately; no DONE; a following START (1234 vs 1234) completes normally with ZERO=1.
6. Parameter sweep DIGIT=16 and DIGIT=1 (WIDTH=16) -> BUSY lasts 1 and 16 cycles respectively; a randomised 1000-vector compare against a reference model matches ZERO/SIGN/BORROW/DIFF in both modes.
